// File: rtl/bus_arbiter_pkg.sv
// Shared types and widths for the IFU/LSU memory bus arbiter.
package bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_STRB_W = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } bus_arb_state_t;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } bus_owner_t;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store.
// LSU wins ties; a streak counter forces IFU through after MAX_LSU_STREAK LSU grants.
//
// state | meaning
// IDLE  | no owner, arbitrating every cycle
// REQ   | request registered on the bus, waiting for bus_req_ready
// WAIT  | request accepted, waiting for bus_resp_valid
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  ifu_req_valid,
    input  logic [BUS_ADDR_W-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [BUS_DATA_W-1:0] ifu_resp_rdata,

    input  logic                  lsu_req_valid,
    input  logic                  lsu_req_we,
    input  logic [BUS_ADDR_W-1:0] lsu_req_addr,
    input  logic [BUS_DATA_W-1:0] lsu_req_wdata,
    input  logic [BUS_STRB_W-1:0] lsu_req_wstrb,
    output logic                  lsu_resp_valid,
    output logic [BUS_DATA_W-1:0] lsu_resp_rdata,

    output logic                  bus_req_valid,
    output logic                  bus_req_we,
    output logic [BUS_ADDR_W-1:0] bus_req_addr,
    output logic [BUS_DATA_W-1:0] bus_req_wdata,
    output logic [BUS_STRB_W-1:0] bus_req_wstrb,
    input  logic                  bus_req_ready,
    input  logic                  bus_resp_valid,
    input  logic [BUS_DATA_W-1:0] bus_resp_rdata,

    output logic                  busy
);

    localparam int STREAK_W = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

    bus_arb_state_t        state, state_nxt;
    bus_owner_t            owner, owner_nxt;
    logic [STREAK_W-1:0]   streak, streak_nxt;
    logic                  drop, drop_nxt;

    logic                  req_we_nxt;
    logic [BUS_ADDR_W-1:0] req_addr_nxt;
    logic [BUS_DATA_W-1:0] req_wdata_nxt;
    logic [BUS_STRB_W-1:0] req_wstrb_nxt;

    logic                  ifu_eff;
    logic                  streak_full;
    logic                  grant_ifu;
    logic                  grant_lsu;
    logic                  resp_fire;

    // A flushed fetch must never win arbitration, even for a single cycle.
    assign ifu_eff     = ifu_req_valid & ~flush;
    assign streak_full = (streak == STREAK_MAX);
    assign grant_ifu   = ifu_eff & (~lsu_req_valid | streak_full);
    assign grant_lsu   = lsu_req_valid & ~grant_ifu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWNER_LSU;
            streak        <= '0;
            drop          <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_wstrb <= '0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            streak        <= streak_nxt;
            drop          <= drop_nxt;
            bus_req_we    <= req_we_nxt;
            bus_req_addr  <= req_addr_nxt;
            bus_req_wdata <= req_wdata_nxt;
            bus_req_wstrb <= req_wstrb_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        streak_nxt    = streak;
        drop_nxt      = drop;
        req_we_nxt    = bus_req_we;
        req_addr_nxt  = bus_req_addr;
        req_wdata_nxt = bus_req_wdata;
        req_wstrb_nxt = bus_req_wstrb;

        unique case (state)
            IDLE: begin
                if (grant_ifu) begin
                    state_nxt     = REQ;
                    owner_nxt     = OWNER_IFU;
                    streak_nxt    = '0;
                    drop_nxt      = 1'b0;
                    req_we_nxt    = 1'b0;
                    req_addr_nxt  = ifu_req_addr;
                    req_wdata_nxt = '0;
                    req_wstrb_nxt = '0;
                end else if (grant_lsu) begin
                    state_nxt     = REQ;
                    owner_nxt     = OWNER_LSU;
                    drop_nxt      = 1'b0;
                    req_we_nxt    = lsu_req_we;
                    req_addr_nxt  = lsu_req_addr;
                    req_wdata_nxt = lsu_req_wdata;
                    req_wstrb_nxt = lsu_req_wstrb;
                    // Only a grant that made IFU wait extends the streak.
                    if (ifu_eff) begin
                        streak_nxt = streak_full ? streak : streak + 1'b1;
                    end else begin
                        streak_nxt = '0;
                    end
                end
            end
            REQ: begin
                if (flush && owner == OWNER_IFU) begin
                    drop_nxt = 1'b1;
                end
                if (bus_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush && owner == OWNER_IFU) begin
                    drop_nxt = 1'b1;
                end
                if (bus_resp_valid) begin
                    state_nxt = IDLE;
                    drop_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Responses outside WAIT are stale and never reach a requester.
    assign resp_fire      = (state == WAIT) & bus_resp_valid & ~rst;
    assign lsu_resp_valid = resp_fire & (owner == OWNER_LSU);
    assign ifu_resp_valid = resp_fire & (owner == OWNER_IFU) & ~drop & ~flush;
    assign lsu_resp_rdata = lsu_resp_valid ? bus_resp_rdata : '0;
    assign ifu_resp_rdata = ifu_resp_valid ? bus_resp_rdata : '0;

    assign bus_req_valid  = (state == REQ);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a transaction-level model predicts
// grants and responses, a negedge monitor compares what the DUT presents.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int MAX_STREAK = 4;
    localparam int N_CYCLES   = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_we = 1'b0;
    logic [31:0] lsu_req_addr = '0;
    logic [31:0] lsu_req_wdata = '0;
    logic [3:0]  lsu_req_wstrb = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        bus_req_valid;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_req_ready = 1'b0;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_resp_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_LSU_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_we(bus_req_we),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
        .bus_req_wstrb(bus_req_wstrb), .bus_req_ready(bus_req_ready),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
        .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef enum int {RESP_NONE, RESP_IFU, RESP_LSU} resp_kind_t;

    typedef struct {
        resp_kind_t  kind;
        logic [31:0] data;
    } resp_t;

    req_t  grant_q[$];
    resp_t resp_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_bus_valid = 1'b0;
    logic exp_busy = 1'b0;
    logic mon_en = 1'b0;

    // Transaction-level model state: 0 free, 1 request posted, 2 awaiting response.
    int   phase = 0;
    int   streak = 0;
    int   wait_cnt = 0;
    logic own_ifu = 1'b0;
    logic dropped = 1'b0;
    logic ifu_done = 1'b0;
    logic lsu_done = 1'b0;
    logic flush_prev = 1'b0;
    int   n_forced_ifu = 0;
    int   n_mid_resets = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_resp(input resp_kind_t k, input logic [31:0] d);
        resp_t r;
        r.kind = k;
        r.data = d;
        resp_q.push_back(r);
    endtask

    task automatic push_grant(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws);
        req_t g;
        g.we    = we;
        g.addr  = a;
        g.wdata = wd;
        g.wstrb = ws;
        grant_q.push_back(g);
    endtask

    task automatic new_lsu();
        lsu_req_valid = 1'b1;
        lsu_req_we    = 1'($urandom_range(0, 1));
        lsu_req_addr  = $urandom & 32'hFFFF_FFFC;
        lsu_req_wdata = $urandom;
        lsu_req_wstrb = lsu_req_we ? 4'($urandom_range(1, 15)) : 4'h0;
    endtask

    task automatic new_ifu();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
    endtask

    // One reset cycle, then a cycle carrying a stale bus response that must be ignored.
    task automatic do_reset();
        logic [31:0] stale;
        rst            = 1'b1;
        flush          = 1'b0;
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        exp_bus_valid  = (phase == 1);
        exp_busy       = (phase != 0);
        @(posedge clk); #1;
        rst        = 1'b0;
        phase      = 0;
        streak     = 0;
        dropped    = 1'b0;
        ifu_done   = 1'b0;
        lsu_done   = 1'b0;
        flush_prev = 1'b0;
        grant_q.delete();
        exp_bus_valid  = 1'b0;
        exp_busy       = 1'b0;
        stale          = $urandom;
        bus_resp_rdata = stale;
        bus_resp_valid = 1'b1;
        push_resp(RESP_NONE, stale);
        #1;
        check("rst_bus_req_we",    bus_req_we,    0);
        check("rst_bus_req_addr",  bus_req_addr,  0);
        check("rst_bus_req_wdata", bus_req_wdata, 0);
        check("rst_bus_req_wstrb", bus_req_wstrb, 0);
        check("rst_ifu_resp_rdata", ifu_resp_rdata, 0);
        check("rst_lsu_resp_rdata", lsu_resp_rdata, 0);
    endtask

    req_t  cur_req;
    resp_t mon_r;
    logic  req_pending = 1'b0;
    logic  cur_ok = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("bus_req_valid", bus_req_valid, exp_bus_valid);
            check("busy", busy, exp_busy);
            if (bus_req_valid) begin
                if (!req_pending) begin
                    if (grant_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        cur_ok = 1'b0;
                        $display("FAIL grant_order: unexpected request addr %h, expected none", bus_req_addr);
                    end else begin
                        cur_req = grant_q.pop_front();
                        cur_ok  = 1'b1;
                    end
                end
                if (cur_ok) begin
                    check("bus_req_we",    bus_req_we,    cur_req.we);
                    check("bus_req_addr",  bus_req_addr,  cur_req.addr);
                    check("bus_req_wdata", bus_req_wdata, cur_req.wdata);
                    check("bus_req_wstrb", bus_req_wstrb, cur_req.wstrb);
                end
                req_pending = !bus_req_ready;
            end else begin
                req_pending = 1'b0;
            end
            if (bus_resp_valid) begin
                if (resp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_order: bus response with no expectation queued");
                end else begin
                    mon_r = resp_q.pop_front();
                    check("ifu_resp_valid", ifu_resp_valid, mon_r.kind == RESP_IFU);
                    check("lsu_resp_valid", lsu_resp_valid, mon_r.kind == RESP_LSU);
                    if (mon_r.kind == RESP_IFU) check("ifu_resp_rdata", ifu_resp_rdata, mon_r.data);
                    if (mon_r.kind == RESP_LSU) check("lsu_resp_rdata", lsu_resp_rdata, mon_r.data);
                end
            end else begin
                check("ifu_resp_idle", ifu_resp_valid, 0);
                check("lsu_resp_idle", lsu_resp_valid, 0);
            end
        end
    end

    initial begin
        int p_lsu, p_ifu, p_flush, p_ready, next_phase;
        logic ifu_eff;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk); #1;

            if (cyc < 2000) begin
                p_lsu = 90; p_ifu = 90; p_flush = 0;  p_ready = 70;
            end else if (cyc < 4000) begin
                p_lsu = 40; p_ifu = 50; p_flush = 8;  p_ready = 60;
            end else begin
                p_lsu = 20; p_ifu = 30; p_flush = 15; p_ready = 25;
            end

            if (cyc >= 2000 && phase == 2 &&
                ($urandom_range(0, 149) == 0 || (cyc >= 3000 && n_mid_resets == 0))) begin
                n_mid_resets++;
                do_reset();
                continue;
            end

            if (ifu_done || flush_prev) ifu_req_valid = 1'b0;
            if (lsu_done) lsu_req_valid = 1'b0;
            ifu_done = 1'b0;
            lsu_done = 1'b0;
            if (!lsu_req_valid && $urandom_range(0, 99) < p_lsu) new_lsu();
            if (!ifu_req_valid && $urandom_range(0, 99) < p_ifu) new_ifu();

            flush          = ($urandom_range(0, 99) < p_flush);
            bus_req_ready  = ($urandom_range(0, 99) < p_ready);
            bus_resp_valid = 1'b0;
            bus_resp_rdata = $urandom;
            exp_bus_valid  = (phase == 1);
            exp_busy       = (phase != 0);
            next_phase     = phase;

            case (phase)
                0: begin
                    ifu_eff = ifu_req_valid && !flush;
                    if (ifu_eff && (!lsu_req_valid || streak == MAX_STREAK)) begin
                        if (lsu_req_valid) n_forced_ifu++;
                        own_ifu = 1'b1;
                        streak  = 0;
                        push_grant(1'b0, ifu_req_addr, 32'h0, 4'h0);
                        dropped    = 1'b0;
                        next_phase = 1;
                    end else if (lsu_req_valid) begin
                        own_ifu = 1'b0;
                        streak  = ifu_eff ? ((streak < MAX_STREAK) ? streak + 1 : streak) : 0;
                        push_grant(lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wstrb);
                        dropped    = 1'b0;
                        next_phase = 1;
                    end
                end
                1: begin
                    if (flush && own_ifu) dropped = 1'b1;
                    if (bus_req_ready) begin
                        next_phase = 2;
                        wait_cnt   = $urandom_range(0, 3);
                    end
                end
                default: begin
                    if (flush && own_ifu) dropped = 1'b1;
                    if (wait_cnt == 0) begin
                        bus_resp_valid = 1'b1;
                        if (!own_ifu) begin
                            push_resp(RESP_LSU, bus_resp_rdata);
                            lsu_done = 1'b1;
                        end else if (!dropped) begin
                            push_resp(RESP_IFU, bus_resp_rdata);
                            ifu_done = 1'b1;
                        end else begin
                            push_resp(RESP_NONE, bus_resp_rdata);
                        end
                        next_phase = 0;
                    end else begin
                        wait_cnt--;
                    end
                end
            endcase

            if (phase != 2 && $urandom_range(0, 99) < 5) begin
                bus_resp_valid = 1'b1;
                push_resp(RESP_NONE, bus_resp_rdata);
            end

            flush_prev = flush;
            phase      = next_phase;
        end

        @(negedge clk); #1;
        $display("info: %0d forced IFU grants, %0d mid-run resets", n_forced_ifu, n_mid_resets);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
